bramtest_axil_arbiter: RTL and testbench
========================================

Name: bramtest_axil_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single bramtest AXI4-Lite slave port (4 × 32-bit registers).
- Each requester issues one read or write at a time on a simple req/done interface.
- The block serialises these requests onto one AXI4-Lite master channel set and returns read data and response.
- Sits between internal control logic (e.g. BIST sequencer, host bridge) and the bramtest S00_AXI port.

Parameters:
- ADDR_WIDTH, 4, AXI byte-address width; registers sit at 0x0/0x4/0x8/0xC.
- DATA_WIDTH, 32, AXI data width; only 32 is supported.

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  synchronous active-low reset
- req  in  2  per-requester request; bit i = requester i
- we  in  2  1 = write, 0 = read; sampled at grant
- addr  in  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]; sampled at grant
- wdata  in  2*DATA_WIDTH  requester i write data; sampled at grant
- gnt  out  2  one-hot; high from grant cycle through done cycle
- done  out  2  one-cycle completion pulse for the granted requester
- rdata  out  DATA_WIDTH  read data, valid while done is high
- resp  out  2  BRESP/RRESP of the completed transaction, valid while done is high
- m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master; awprot=arprot=0, wstrb=all ones
- stat_cnt0, stat_cnt1  out  16  completed transactions per requester (optional feature)
- stat_err  out  16  count of non-OKAY responses (optional feature)

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge): all outputs 0; FSM→IDLE; round-robin pointer last=1, so requester 0 wins the first tie.
- A reset mid-transaction abandons it; no done is issued. The slave shares ARESETN.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE: when any req is high, grant in that cycle.
  - Single requester: grant it.
  - Both: grant ~last.
  - On grant: latch we/addr/wdata, set gnt, update last, go to WADDR (we=1) or RADDR (we=0).
- WADDR: awvalid and wvalid go high on the cycle after grant. Each drops independently after its own handshake (valid&ready). Go to WRESP when both are done, including the same-cycle case.
- WRESP: bready=1. On bvalid, latch bresp; go to DONE.
- RADDR: arvalid=1 until arready; then RDATA.
- RDATA: rready=1. On rvalid, latch rdata and rresp; go to DONE.
- DONE: done[g]=1 for exactly one cycle, with rdata and resp valid. gnt drops the next cycle; go to IDLE.
- No back-to-back grant; a new grant is earliest the cycle after DONE.
- Minimum latency with zero-wait slave: grant at cycle 0, handshake cycle 1, B/R handshake cycle 2, done cycle 3.
- Valids never drop before their handshake. Latched address and data stay stable while valid is high.
- rdata and resp hold their last value outside DONE. After a write, rdata is unchanged.
- req dropped after grant does not abort; the transaction completes and done still pulses.
- A requester holding req high through done is re-arbitrated in IDLE like a new request.
- Address passed unmodified; no alignment check.

Optional Feature:
- Macro: BRAMTEST_ARB_STATS_EN.
- Defined:
  - stat_cnt0/stat_cnt1 increment by 1 on each done of the respective requester.
  - stat_err increments on each done with resp≠2'b00.
  - All three saturate at 0xFFFF and clear on reset.
- Undefined: ports are present but tied to 0; no counter logic.

Test Plan:
- Req0 writes 0x00000001..0x00000004 to 0x0/0x4/0x8/0xC, then reads back with a zero-wait slave → rdata 0x1..0x4, resp=0, done at cycle 3 after each grant.
- req=2'b11 held continuously, each doing 4 writes → grants alternate 0,1,0,1…; first grant goes to requester 0.
- Slave delays awready 3 cycles with wready immediate (and the reverse) → wvalid/awvalid drop independently; exactly one B handshake; one done.
- Slave returns rresp=2'b10 → resp=2'b10 with done. With BRAMTEST_ARB_STATS_EN, stat_err=1.
- ARESETN asserted in WRESP with bvalid pending → next cycle all outputs 0, FSM IDLE, no done; a subsequent req1 read of 0x4 completes normally.
- With BRAMTEST_ARB_STATS_EN: 70000 requester-0 transactions → stat_cnt0=0xFFFF, stat_cnt1=0. Without the macro, all stat ports read 0.

Source files
------------

// File: rtl/bramtest_axil_arbiter.sv
// Two-requester round-robin arbiter serialising single read/write requests onto one AXI4-Lite master.
// Optional statistics counters are built only when BRAMTEST_ARB_STATS_EN is defined.
module bramtest_axil_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [1:0]                req,
  input  logic [1:0]                we,
  input  logic [2*ADDR_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0]   wdata,
  output logic [1:0]                gnt,
  output logic [1:0]                done,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                resp,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [15:0]               stat_cnt0,
  output logic [15:0]               stat_cnt1,
  output logic [15:0]               stat_err
);

  // state   | meaning
  // S_IDLE  | waiting for a request; grants combinationally in this cycle
  // S_WADDR | AW and W channels outstanding, each retired independently
  // S_WRESP | waiting for the write response
  // S_RADDR | AR channel outstanding
  // S_RDATA | waiting for read data
  // S_DONE  | one-cycle completion pulse to the granted requester
  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic                  last;
  logic                  sel;
  logic                  grant;
  logic [1:0]            grant_vec;
  logic [1:0]            gnt_q;
  logic                  aw_done, aw_done_nxt;
  logic                  w_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

  always_comb begin
    sel       = (req == 2'b11) ? ~last : req[1];
    grant     = ARESETN && (state == S_IDLE) && (req != 2'b00);
    grant_vec = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
    addr_sel  = sel ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
    wdata_sel = sel ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
    gnt       = (state == S_IDLE) ? grant_vec : gnt_q;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state   <= S_IDLE;
      last    <= 1'b1;
      gnt_q   <= 2'b00;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      resp    <= 2'b00;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (grant) begin
        last    <= sel;
        gnt_q   <= grant_vec;
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
      end else if (state == S_DONE) begin
        gnt_q <= 2'b00;
      end
      if (state == S_WRESP && m_axi_bvalid) begin
        resp <= m_axi_bresp;
      end
      if (state == S_RDATA && m_axi_rvalid) begin
        rdata <= m_axi_rdata;
        resp  <= m_axi_rresp;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    done          = 2'b00;
    case (state)
      S_IDLE: begin
        if (grant) begin
          state_nxt   = (sel ? we[1] : we[0]) ? S_WADDR : S_RADDR;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      S_WADDR: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        aw_done_nxt   = aw_done | m_axi_awready;
        w_done_nxt    = w_done | m_axi_wready;
        if (aw_done_nxt && w_done_nxt) state_nxt = S_WRESP;
      end
      S_WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = S_DONE;
      end
      S_RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = S_RDATA;
      end
      S_RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = gnt_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;

`ifdef BRAMTEST_ARB_STATS_EN
  // Counters observe the latched response during the done cycle and saturate.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      stat_cnt0 <= 16'h0000;
      stat_cnt1 <= 16'h0000;
      stat_err  <= 16'h0000;
    end else if (state == S_DONE) begin
      if (gnt_q[0] && stat_cnt0 != 16'hFFFF) stat_cnt0 <= stat_cnt0 + 16'h0001;
      if (gnt_q[1] && stat_cnt1 != 16'hFFFF) stat_cnt1 <= stat_cnt1 + 16'h0001;
      if (resp != 2'b00 && stat_err != 16'hFFFF) stat_err <= stat_err + 16'h0001;
    end
  end
`else
  assign stat_cnt0 = 16'h0000;
  assign stat_cnt1 = 16'h0000;
  assign stat_err  = 16'h0000;
`endif

endmodule

// File: tb/tb_bramtest_axil_arbiter.sv
// Bench for bramtest_axil_arbiter: behavioural 4-register AXI4-Lite slave with programmable
// ready delays and response codes, plus a transaction-level reference of the arbiter.
module tb_bramtest_axil_arbiter;

  logic        ACLK;
  logic        ARESETN;
  logic [1:0]  req, we;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [1:0]  gnt, done, resp;
  logic [31:0] rdata;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [15:0] stat_cnt0, stat_cnt1, stat_err;

  bramtest_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .resp(resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_err(stat_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0]  slv_resp = 2'b00;
  int          aw_wait, w_wait, ar_wait;
  logic        aw_got, w_got;
  logic [3:0]  aw_a;
  logic [31:0] w_d;
  logic [31:0] mem [4];
  logic        aw_hs, w_hs, aw_now, w_now;
  logic [3:0]  slv_wa;
  logic [31:0] slv_wd;

  assign m_axi_awready = m_axi_awvalid && !aw_got && (aw_wait >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid && !w_got && (w_wait >= w_dly);
  assign m_axi_arready = m_axi_arvalid && !m_axi_rvalid && (ar_wait >= ar_dly);
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign aw_now = aw_got || aw_hs;
  assign w_now  = w_got || w_hs;
  assign slv_wa = aw_got ? aw_a : m_axi_awaddr;
  assign slv_wd = w_got ? w_d : m_axi_wdata;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= 4'h0; w_d <= 32'h0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= 32'h0;
      for (int i = 0; i < 4; i++) mem[i] <= 32'h0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= m_axi_awaddr; aw_wait <= 0; end
      else if (m_axi_awvalid) aw_wait <= aw_wait + 1;
      if (w_hs) begin w_got <= 1'b1; w_d <= m_axi_wdata; w_wait <= 0; end
      else if (m_axi_wvalid) w_wait <= w_wait + 1;
      if (aw_now && w_now && !m_axi_bvalid) begin
        mem[slv_wa[3:2]] <= slv_wd;
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= slv_resp;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem[m_axi_araddr[3:2]];
        m_axi_rresp  <= slv_resp;
        ar_wait      <= 0;
      end else if (m_axi_arvalid) ar_wait <= ar_wait + 1;
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- activity monitor ----------------
  int done_cnt = 0, aw_cyc = 0, w_cyc = 0, b_hs_cnt = 0;
  always @(posedge ACLK) begin
    if (done != 2'b00) done_cnt <= done_cnt + 1;
    if (m_axi_awvalid) aw_cyc <= aw_cyc + 1;
    if (m_axi_wvalid) w_cyc <= w_cyc + 1;
    if (m_axi_bvalid && m_axi_bready) b_hs_cnt <= b_hs_cnt + 1;
  end

  // ---------------- reference model state ----------------
  int          tests = 0, fails = 0;
  logic [31:0] exp_mem [4];
  logic [31:0] exp_rd;
  int          exp_last;
  int          m_cnt0, m_cnt1, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) exp_mem[i] = 32'h0;
    exp_rd = 32'h0; exp_last = 1; m_cnt0 = 0; m_cnt1 = 0; m_err = 0;
  endtask

  task automatic model_done(input int r, input logic w, input logic [3:0] a, input logic [31:0] d);
    if (w) exp_mem[a[3:2]] = d;
    else exp_rd = exp_mem[a[3:2]];
    exp_last = r;
    if (r == 0 && m_cnt0 < 16'hFFFF) m_cnt0++;
    if (r == 1 && m_cnt1 < 16'hFFFF) m_cnt1++;
    if (slv_resp != 2'b00 && m_err < 16'hFFFF) m_err++;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0; req = 2'b00;
    @(negedge ACLK);
    ARESETN = 1'b1;
    model_clear();
  endtask

  task automatic check_stats(input string tag);
`ifdef BRAMTEST_ARB_STATS_EN
    chk({tag, "_cnt0"}, 32'(stat_cnt0), 32'(m_cnt0));
    chk({tag, "_cnt1"}, 32'(stat_cnt1), 32'(m_cnt1));
    chk({tag, "_err"}, 32'(stat_err), 32'(m_err));
`else
    chk({tag, "_off"}, 32'(stat_cnt0) | 32'(stat_cnt1) | 32'(stat_err), 32'h0);
`endif
  endtask

  // One isolated request: grant seen in the request cycle, done at the latency implied by the slave delays.
  task automatic txn(input int r, input logic w, input logic [3:0] a, input logic [31:0] d);
    int n, lat, awc0, wc0, b0;
    logic [1:0] oh;
    oh  = (r == 0) ? 2'b01 : 2'b10;
    lat = w ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) : 3 + ar_dly;
    @(negedge ACLK);
    awc0 = aw_cyc; wc0 = w_cyc; b0 = b_hs_cnt;
    req[r] = 1'b1; we[r] = w; addr[r*4 +: 4] = a; wdata[r*32 +: 32] = d;
    #1;
    chk("gnt_at_req", 32'(gnt), 32'(oh));
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (n == 1) req[r] = 1'b0;
    end while (done == 2'b00 && n < 40);
    model_done(r, w, a, d);
    chk("done_pulse", 32'(done), 32'(oh));
    chk("latency", n, lat);
    chk("rdata", rdata, exp_rd);
    chk("resp", 32'(resp), 32'(slv_resp));
    chk("gnt_at_done", 32'(gnt), 32'(oh));
    if (w) begin
      chk("awvalid_cycles", aw_cyc - awc0, aw_dly + 1);
      chk("wvalid_cycles", w_cyc - wc0, w_dly + 1);
      chk("b_handshakes", b_hs_cnt - b0, 1);
    end
    @(negedge ACLK);
    chk("done_single", 32'(done), 32'h0);
    chk("gnt_release", 32'(gnt), 32'h0);
  endtask

  initial begin
    int n, er, dc0;
    logic [1:0] oh;
    logic [3:0] ra;
    logic [31:0] rd;

    ARESETN = 1'b0; req = 2'b00; we = 2'b00; addr = 8'h0; wdata = 64'h0;
    model_clear();
    repeat (3) @(negedge ACLK);
    chk("rst_ctl", 32'({gnt, done, resp, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                        m_axi_arvalid, m_axi_rready}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    check_stats("rst_stat");
    ARESETN = 1'b1;

    // Directed fill and read-back with a zero-wait slave.
    for (int i = 0; i < 4; i++) txn(0, 1'b1, 4'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) txn(0, 1'b0, 4'(i * 4), 32'h0);
    check_stats("fill_stat");

    // Both requesters held high: strict alternation starting at requester 0.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      we[r] = 1'b1; addr[r*4 +: 4] = 4'($urandom_range(0, 3)) << 2; wdata[r*32 +: 32] = $urandom;
    end
    @(negedge ACLK);
    req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin @(negedge ACLK); n++; end while (done == 2'b00 && n < 40);
      er = (exp_last == 1) ? 0 : 1;
      oh = (er == 0) ? 2'b01 : 2'b10;
      chk("rr_winner", 32'(done), 32'(oh));
      chk("rr_spacing", n, (k == 0) ? 3 : 4);
      model_done(er, 1'b1, addr[er*4 +: 4], wdata[er*32 +: 32]);
      addr[er*4 +: 4] = 4'($urandom_range(0, 3)) << 2;
      wdata[er*32 +: 32] = $urandom;
      if (k == 7) req = 2'b00;
    end
    for (int i = 0; i < 4; i++) txn(1, 1'b0, 4'(i * 4), 32'h0);
    check_stats("rr_stat");

    // Independent AW/W retirement.
    aw_dly = 3; w_dly = 0;
    txn(0, 1'b1, 4'h8, 32'hA5A5_0001);
    aw_dly = 0; w_dly = 3;
    txn(1, 1'b1, 4'hC, 32'h5A5A_0002);
    w_dly = 0;
    txn(0, 1'b0, 4'h8, 32'h0);

    // Error response on a read.
    slv_resp = 2'b10;
    txn(1, 1'b0, 4'hC, 32'h0);
    slv_resp = 2'b00;
    check_stats("err_stat");

    // Randomised traffic with random handshake delays and occasional error responses.
    for (int k = 0; k < 24; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      slv_resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      ra = 4'($urandom_range(0, 3)) << 2;
      rd = $urandom;
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rd);
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; slv_resp = 2'b00;
    check_stats("rand_stat");

    // Reset while the write response is pending: abandoned, no done.
    @(negedge ACLK);
    req[1] = 1'b1; we[1] = 1'b1; addr[7:4] = 4'h8; wdata[63:32] = 32'hDEAD_BEEF;
    @(negedge ACLK);
    req[1] = 1'b0;
    @(negedge ACLK);
    chk("bvalid_pending", 32'(m_axi_bvalid & m_axi_bready), 32'h1);
    dc0 = done_cnt;
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_ctl", 32'({gnt, done, resp, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                            m_axi_arvalid, m_axi_rready}), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_addr", 32'({m_axi_awaddr, m_axi_araddr}), 32'h0);
    chk("mid_rst_wdata", m_axi_wdata, 32'h0);
    ARESETN = 1'b1;
    model_clear();
    repeat (3) @(negedge ACLK);
    chk("no_done_after_rst", done_cnt, dc0);
    txn(1, 1'b0, 4'h4, 32'h0);
    txn(1, 1'b1, 4'h4, 32'h1234_5678);
    txn(1, 1'b0, 4'h4, 32'h0);
    check_stats("post_rst_stat");

`ifdef BRAMTEST_ARB_STATS_EN
    // Saturation: a long run of requester-0 reads.
    do_reset();
    @(negedge ACLK);
    dc0 = done_cnt;
    we[0] = 1'b0; addr[3:0] = 4'h0; req[0] = 1'b1;
    n = 0;
    while (done_cnt - dc0 < 70000 && n < 400000) begin @(negedge ACLK); n++; end
    req[0] = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("sat_done_count", done_cnt - dc0, 70000);
    chk("sat_cnt0", 32'(stat_cnt0), 32'hFFFF);
    chk("sat_cnt1", 32'(stat_cnt1), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
